id_ex_stage_reg: RTL

//  ID/EX pipeline register with built-in load-use hazard detection. Captures the

---
 rtl/id_ex_stage_reg.sv | 117 +++++++++++
 1 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and stall.
// Define ID_EX_BUBBLE_CNT_EN to add the saturating bubble_count output.
module id_ex_stage_reg #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned INST_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_valid,
  input  logic [INST_W-1:0] ID_inst,
  input  logic              ID_reg_write_signal,
  input  logic              ID_mem_read,
  input  logic              ID_mem_write,
  input  logic              ID_reg2_read_source,
  input  logic [DATA_W-1:0] ID_read_data1,
  input  logic [DATA_W-1:0] ID_read_data2,
  input  logic              flush,
  input  logic              hold,
  output logic              EX_valid,
  output logic [INST_W-1:0] EX_inst,
  output logic              EX_reg_write_signal,
  output logic              EX_mem_read,
  output logic              EX_mem_write,
  output logic              EX_reg2_read_source,
  output logic [DATA_W-1:0] EX_read_data1,
  output logic [DATA_W-1:0] EX_read_data2,
  output logic              stall
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [15:0]       bubble_count
`endif
);

  logic [2:0] ex_dest;
  logic [2:0] id_src_a;
  logic [2:0] id_src_b;
  logic       hz;
  logic       bubble;

  logic              valid_d;
  logic [INST_W-1:0] inst_d;
  logic              reg_write_d;
  logic              mem_read_d;
  logic              mem_write_d;
  logic              reg2_src_d;
  logic [DATA_W-1:0] data1_d;
  logic [DATA_W-1:0] data2_d;

  assign ex_dest  = EX_inst[13:11];
  assign id_src_a = ID_inst[10:8];
  assign id_src_b = ID_reg2_read_source ? ID_inst[10:8] : ID_inst[7:5];

  // r0 is never a real destination, so a load to r0 cannot create a hazard.
  assign hz = ID_valid & EX_valid & EX_mem_read & (ex_dest != 3'd0) &
              ((ex_dest == id_src_a) | (ex_dest == id_src_b));

  // A flush discards the ID instruction, so there is nothing to hold back.
  assign stall  = hz & ~flush;
  assign bubble = flush | hz;

  always_comb begin
    valid_d     = ID_valid;
    inst_d      = ID_inst;
    reg_write_d = ID_reg_write_signal;
    mem_read_d  = ID_mem_read;
    mem_write_d = ID_mem_write;
    reg2_src_d  = ID_reg2_read_source;
    data1_d     = ID_read_data1;
    data2_d     = ID_read_data2;
    if (bubble) begin
      // Zero inst gives dest r0, which downstream forwarding never matches.
      valid_d     = 1'b0;
      inst_d      = '0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      reg2_src_d  = 1'b0;
      data1_d     = '0;
      data2_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      EX_valid            <= 1'b0;
      EX_inst             <= '0;
      EX_reg_write_signal <= 1'b0;
      EX_mem_read         <= 1'b0;
      EX_mem_write        <= 1'b0;
      EX_reg2_read_source <= 1'b0;
      EX_read_data1       <= '0;
      EX_read_data2       <= '0;
    end else if (!hold) begin
      EX_valid            <= valid_d;
      EX_inst             <= inst_d;
      EX_reg_write_signal <= reg_write_d;
      EX_mem_read         <= mem_read_d;
      EX_mem_write        <= mem_write_d;
      EX_reg2_read_source <= reg2_src_d;
      EX_read_data1       <= data1_d;
      EX_read_data2       <= data2_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (!hold && bubble && (bubble_count != 16'hFFFF)) begin
      bubble_count <= bubble_count + 16'd1;
    end
  end
`else
  // Bubble counter not built.
`endif

endmodule
